// File: rtl/flag_gen_pkg.sv
// flag_gen_pkg: shared definitions for the multi-cycle flag producer.
//   - operation encodings presented on the op input
//   - FSM state encoding
//   - condition-code evaluation helpers (EQUAL, LESS, GREATER,
//     GREATER_OR_EQUAL) that consume the z/v/n flags produced by flag_gen
package flag_gen_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_CMP = 2'b10;  // subtract, flags only
    localparam logic [OP_W-1:0] OP_AND = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Signed-compare condition codes built from the flag register.
    function automatic logic cc_equal(input logic z);
        return z;
    endfunction

    function automatic logic cc_less(input logic n, input logic v);
        return n ^ v;
    endfunction

    function automatic logic cc_greater(input logic z, input logic n, input logic v);
        return ~z & ~(n ^ v);
    endfunction

    function automatic logic cc_greater_or_equal(input logic n, input logic v);
        return ~(n ^ v);
    endfunction

endpackage

// File: rtl/flag_gen_if.sv
// flag_gen_if: request/result bundle between a requester and flag_gen.
//   master : drives start/op/a/b, observes busy/done/result/flags/strobes
//   slave  : flag_gen side of the same signals
interface flag_gen_if #(
    parameter int WIDTH = 16
);
    import flag_gen_pkg::*;

    logic              start;
    logic [OP_W-1:0]   op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              z;
    logic              v;
    logic              n;
    logic              flag_we;
    logic              result_we;

    modport master (
        output start, op, a, b,
        input  busy, done, result, z, v, n, flag_we, result_we
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, z, v, n, flag_we, result_we
    );

endinterface

// File: rtl/flag_gen_slice.sv
// flag_gen_slice: combinational DIGIT-bit adder / AND slice.
//   a, b            : operand digits
//   carry_in        : carry from the previous (less significant) slice
//   invert_b        : add ~b instead of b (subtract when carry_in starts at 1)
//   and_mode        : produce a & b, carries forced to 0
//   sum             : slice result
//   carry_out       : carry out of the slice MSB
//   carry_into_msb  : carry into the slice MSB (overflow detection)
module flag_gen_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             carry_in,
    input  logic             invert_b,
    input  logic             and_mode,
    output logic [DIGIT-1:0] sum,
    output logic             carry_out,
    output logic             carry_into_msb
);

    logic [DIGIT-1:0] b_eff_s;
    logic [DIGIT:0]   full_s;
    logic [DIGIT-1:0] low_s;

    // Full slice add plus a separate add of the lower bits to expose the carry into the MSB.
    always_comb begin
        b_eff_s = invert_b ? ~b : b;
        full_s  = {1'b0, a} + {1'b0, b_eff_s} + {{DIGIT{1'b0}}, carry_in};
        low_s   = {1'b0, a[DIGIT-2:0]} + {1'b0, b_eff_s[DIGIT-2:0]}
                + {{(DIGIT-1){1'b0}}, carry_in};
        if (and_mode) begin
            sum            = a & b;
            carry_out      = 1'b0;
            carry_into_msb = 1'b0;
        end else begin
            sum            = full_s[DIGIT-1:0];
            carry_out      = full_s[DIGIT];
            carry_into_msb = low_s[DIGIT-1];
        end
    end

endmodule

// File: rtl/flag_gen.sv
// flag_gen: multi-cycle ALU flag producer.
//   Accepts a, b, op when idle and start is high, then processes one DIGIT-bit
//   slice per cycle, LSB first. After K = WIDTH/DIGIT slices it pulses done,
//   flag_we and (for everything but CMP) result_we for one cycle, and updates
//   the held z/v/n flags and, unless CMP, the held result.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : flag_gen_if slave modport (start/op/a/b in; busy/done/result/z/v/n/
//           flag_we/result_we out, all registered)
module flag_gen
    import flag_gen_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    flag_gen_if.slave   bus
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    state_t            state_q,     state_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic [WIDTH-1:0]  a_sh_q,      a_sh_d;
    logic [WIDTH-1:0]  b_sh_q,      b_sh_d;
    logic [WIDTH-1:0]  tmp_q,       tmp_d;
    logic [OP_W-1:0]   op_q,        op_d;
    logic              carry_q,     carry_d;
    logic              zero_q,      zero_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              result_we_q, result_we_d;
    logic [WIDTH-1:0]  result_q,    result_d;
    logic              z_q,         z_d;
    logic              v_q,         v_d;
    logic              n_q,         n_d;

    logic [DIGIT-1:0]  slice_sum_s;
    logic              slice_cout_s;
    logic              slice_cim_s;
    logic              is_sub_s;
    logic              is_and_s;

    assign is_sub_s = (op_q == OP_SUB) || (op_q == OP_CMP);
    assign is_and_s = (op_q == OP_AND);

    flag_gen_slice #(.DIGIT(DIGIT)) u_slice (
        .a              (a_sh_q[DIGIT-1:0]),
        .b              (b_sh_q[DIGIT-1:0]),
        .carry_in       (carry_q),
        .invert_b       (is_sub_s),
        .and_mode       (is_and_s),
        .sum            (slice_sum_s),
        .carry_out      (slice_cout_s),
        .carry_into_msb (slice_cim_s)
    );

    // Next-state logic: accept in IDLE, one slice per RUN cycle, finish on the last slice.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        tmp_d       = tmp_q;
        op_d        = op_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_we_d = 1'b0;
        result_d    = result_q;
        z_d         = z_q;
        v_d         = v_q;
        n_d         = n_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    op_d    = bus.op;
                    cnt_d   = {CW{1'b0}};
                    // Carry-in of 1 completes the two's-complement of b.
                    carry_d = (bus.op == OP_SUB) || (bus.op == OP_CMP);
                    zero_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                // Slices enter at the top so the first slice ends up in the LSBs.
                tmp_d   = {slice_sum_s, tmp_q[WIDTH-1:DIGIT]};
                carry_d = slice_cout_s;
                zero_d  = zero_q & (slice_sum_s == {DIGIT{1'b0}});
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(K - 1)) begin
                    state_d     = ST_IDLE;
                    cnt_d       = {CW{1'b0}};
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    result_we_d = (op_q != OP_CMP);
                    n_d         = slice_sum_s[DIGIT-1];
                    z_d         = zero_d;
                    v_d         = is_and_s ? 1'b0 : (slice_cim_s ^ slice_cout_s);
                    if (op_q != OP_CMP) begin
                        result_d = tmp_d;
                    end else begin
                        result_d = result_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            a_sh_q      <= {WIDTH{1'b0}};
            b_sh_q      <= {WIDTH{1'b0}};
            tmp_q       <= {WIDTH{1'b0}};
            op_q        <= OP_ADD;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_we_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            z_q         <= 1'b0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            tmp_q       <= tmp_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_we_q <= result_we_d;
            result_q    <= result_d;
            z_q         <= z_d;
            v_q         <= v_d;
            n_q         <= n_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.flag_we   = done_q;
    assign bus.result_we = result_we_q;
    assign bus.result    = result_q;
    assign bus.z         = z_q;
    assign bus.v         = v_q;
    assign bus.n         = n_q;

endmodule

// File: tb/tb_flag_gen.sv
// tb_flag_gen: directed, table-driven bench for flag_gen (WIDTH=16, DIGIT=4).
module tb_flag_gen;
    import flag_gen_pkg::*;

    localparam int WIDTH = 16;
    localparam int K     = 4;

    logic clk;
    logic rst_n;

    flag_gen_if #(.WIDTH(WIDTH)) bus ();

    flag_gen #(.WIDTH(WIDTH), .DIGIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        v;
    } vec_t;

    vec_t vecs[10];

    int          checks;
    int          errors;
    logic [15:0] held_result;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and check the full cycle-by-cycle response.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input logic ez, input logic en,
                          input logic ev);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;       // must not disturb the operation in flight
        bus.b     = ~b;
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        chk("done_at_accept", {31'd0, bus.done}, 32'd0);
        for (int i = 1; i < K; i++) begin
            @(posedge clk);
            #1;
            chk("done_early", {31'd0, bus.done}, 32'd0);
            chk("busy_run", {31'd0, bus.busy}, 32'd1);
        end
        @(posedge clk);
        #1;
        if (op != OP_CMP) held_result = exp_res;
        chk("done_pulse", {31'd0, bus.done}, 32'd1);
        chk("flag_we", {31'd0, bus.flag_we}, 32'd1);
        chk("result_we", {31'd0, bus.result_we}, {31'd0, (op != OP_CMP)});
        chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
        chk("result", {16'd0, bus.result}, {16'd0, held_result});
        chk("z", {31'd0, bus.z}, {31'd0, ez});
        chk("n", {31'd0, bus.n}, {31'd0, en});
        chk("v", {31'd0, bus.v}, {31'd0, ev});
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
        chk("flag_we_one_cycle", {31'd0, bus.flag_we}, 32'd0);
        chk("result_we_one_cycle", {31'd0, bus.result_we}, 32'd0);
        chk("result_held", {16'd0, bus.result}, {16'd0, held_result});
    endtask

    initial begin
        int done_cnt;
        int done_at[2];
        logic [15:0] done_res[2];

        checks      = 0;
        errors      = 0;
        held_result = 16'h0000;

        vecs[0] = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{OP_CMP, 16'h0003, 16'h0007, 16'hFFFC, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{OP_AND, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{OP_AND, 16'hFF00, 16'h0F0F, 16'h0F00, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{OP_CMP, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_flag_we", {31'd0, bus.flag_we}, 32'd0);
        chk("rst_result_we", {31'd0, bus.result_we}, 32'd0);
        chk("rst_result", {16'd0, bus.result}, 32'd0);
        chk("rst_znv", {29'd0, bus.z, bus.n, bus.v}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].z, vecs[i].n, vecs[i].v);
            if (i == 1 || i == 2) chk("less_true", {31'd0, bus.n ^ bus.v}, 32'd1);
        end

        // start held high: ADD 1+2, then SUB 0x10-3 accepted in the done cycle.
        done_cnt = 0;
        done_at[0] = -1; done_at[1] = -1;
        done_res[0] = 16'h0000; done_res[1] = 16'h0000;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 16'h0001;
        bus.b     = 16'h0002;
        @(posedge clk);
        #1;
        bus.op    = OP_SUB;
        bus.a     = 16'h0010;
        bus.b     = 16'h0003;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (done_cnt < 2) begin
                    done_at[done_cnt]  = c;
                    done_res[done_cnt] = bus.result;
                end
                done_cnt++;
            end
            if (c >= 5 && c <= 8) chk("b2b_busy_second", {31'd0, bus.busy}, 32'd1);
            if (c == 9) bus.start = 1'b0;
        end
        chk("b2b_done_count", done_cnt, 32'd2);
        chk("b2b_first_done", done_at[0], 32'd4);
        chk("b2b_second_done", done_at[1], 32'd9);
        chk("b2b_first_result", {16'd0, done_res[0]}, 32'h0003);
        chk("b2b_second_result", {16'd0, done_res[1]}, 32'h000D);
        chk("b2b_idle_after", {31'd0, bus.busy}, 32'd0);
        held_result = 16'h000D;

        // Make flags/result non-zero so the reset clear is visible.
        run_op(OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0);

        // Reset in the second RUN cycle of ADD 0x1234+0x1111.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 16'h1234;
        bus.b     = 16'h1111;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_done", {31'd0, bus.done}, 32'd0);
        chk("arst_result", {16'd0, bus.result}, 32'd0);
        chk("arst_znv", {29'd0, bus.z, bus.n, bus.v}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        held_result = 16'h0000;
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_cnt++;
        end
        chk("no_done_after_reset", done_cnt, 32'd0);
        run_op(OP_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
